// File: rtl/rv_iommu_axi4_err_resp.sv
// AXI4 error responder for rejected IOMMU requests: SLVERR read bursts and drained writes with SLVERR B.
// `define RV_IOMMU_ERR_RESP_WCNT_EN to end W drain by beat count instead of w_last_i.
module rv_iommu_axi4_err_resp #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_req_i,
  input  logic [ID_WIDTH-1:0]   rd_id_i,
  input  logic [7:0]            rd_len_i,
  output logic                  rd_ready_o,
  output logic                  r_valid_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic [USER_WIDTH-1:0] r_user_o,
  input  logic                  r_ready_i,
  input  logic                  wr_req_i,
  input  logic [ID_WIDTH-1:0]   wr_id_i,
  input  logic [7:0]            wr_len_i,
  output logic                  wr_ready_o,
  input  logic                  w_valid_i,
  input  logic                  w_last_i,
  output logic                  w_ready_o,
  output logic                  b_valid_o,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  input  logic                  b_ready_i
);

  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DRAIN = 2'd1, W_RESP = 2'd2} wr_state_t;

  rd_state_t           r_rd_state;
  logic [7:0]          r_rd_cnt;
  logic [ID_WIDTH-1:0] r_rid;
  logic                r_rd_ready;
  logic                r_rvalid;
  logic                r_rlast;

  wr_state_t           r_wr_state;
  logic [7:0]          r_wr_cnt;
  logic [ID_WIDTH-1:0] r_bid;
  logic                r_wr_ready;
  logic                r_wready;
  logic                r_bvalid;
  logic                w_drain_done;

  // Read side: r_rlast is precomputed so it is valid in the same cycle as the beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= 8'd0;
      r_rid      <= {ID_WIDTH{1'b0}};
      r_rd_ready <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (rd_req_i) begin
            r_rid      <= rd_id_i;
            r_rd_cnt   <= rd_len_i;
            r_rd_ready <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rlast    <= (rd_len_i == 8'd0);
            r_rd_state <= R_BURST;
          end
        end
        R_BURST: begin
          if (r_rvalid && r_ready_i) begin
            if (r_rd_cnt == 8'd0) begin
              r_rvalid   <= 1'b0;
              r_rlast    <= 1'b0;
              r_rd_ready <= 1'b1;
              r_rd_state <= R_IDLE;
            end else begin
              r_rd_cnt <= r_rd_cnt - 8'd1;
              r_rlast  <= (r_rd_cnt == 8'd1);
            end
          end
        end
        default: begin
          r_rd_state <= R_IDLE;
          r_rd_ready <= 1'b1;
          r_rvalid   <= 1'b0;
          r_rlast    <= 1'b0;
        end
      endcase
    end
  end

`ifdef RV_IOMMU_ERR_RESP_WCNT_EN
  assign w_drain_done = (r_wr_cnt == 8'd0);
`else
  assign w_drain_done = w_last_i;
`endif

  // Write side: the counter saturates at zero; it only ends the drain in count mode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= 8'd0;
      r_bid      <= {ID_WIDTH{1'b0}};
      r_wr_ready <= 1'b1;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (wr_req_i) begin
            r_bid      <= wr_id_i;
            r_wr_cnt   <= wr_len_i;
            r_wr_ready <= 1'b0;
            r_wready   <= 1'b1;
            r_wr_state <= W_DRAIN;
          end
        end
        W_DRAIN: begin
          if (w_valid_i) begin
            if (r_wr_cnt != 8'd0) begin
              r_wr_cnt <= r_wr_cnt - 8'd1;
            end
            if (w_drain_done) begin
              r_wready   <= 1'b0;
              r_bvalid   <= 1'b1;
              r_wr_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            r_bvalid   <= 1'b0;
            r_wr_ready <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: begin
          r_wr_state <= W_IDLE;
          r_wr_ready <= 1'b1;
          r_wready   <= 1'b0;
          r_bvalid   <= 1'b0;
        end
      endcase
    end
  end

  assign rd_ready_o = r_rd_ready;
  assign r_valid_o  = r_rvalid;
  assign r_id_o     = r_rid;
  assign r_data_o   = {DATA_WIDTH{1'b0}};
  assign r_resp_o   = 2'b10;
  assign r_last_o   = r_rlast;
  assign r_user_o   = {USER_WIDTH{1'b0}};
  assign wr_ready_o = r_wr_ready;
  assign w_ready_o  = r_wready;
  assign b_valid_o  = r_bvalid;
  assign b_id_o     = r_bid;
  assign b_resp_o   = 2'b10;

endmodule

// File: tb/tb_rv_iommu_axi4_err_resp.sv
// Randomized self-checking bench for rv_iommu_axi4_err_resp; expected beats come from a beat-count model.
module tb_rv_iommu_axi4_err_resp;
  localparam int IW = 4;
  localparam int DW = 64;
  localparam int UW = 1;
`ifdef RV_IOMMU_ERR_RESP_WCNT_EN
  localparam bit CNT_MODE = 1'b1;
`else
  localparam bit CNT_MODE = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          rd_req_i, rd_ready_o, r_valid_o, r_last_o, r_ready_i;
  logic [IW-1:0] rd_id_i, r_id_o;
  logic [7:0]    rd_len_i;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_resp_o, b_resp_o;
  logic [UW-1:0] r_user_o;
  logic          wr_req_i, wr_ready_o, w_valid_i, w_last_i, w_ready_o, b_valid_o, b_ready_i;
  logic [IW-1:0] wr_id_i, b_id_o;
  logic [7:0]    wr_len_i;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  rv_iommu_axi4_err_resp #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_req_i(rd_req_i), .rd_id_i(rd_id_i), .rd_len_i(rd_len_i), .rd_ready_o(rd_ready_o),
    .r_valid_o(r_valid_o), .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
    .r_last_o(r_last_o), .r_user_o(r_user_o), .r_ready_i(r_ready_i),
    .wr_req_i(wr_req_i), .wr_id_i(wr_id_i), .wr_len_i(wr_len_i), .wr_ready_o(wr_ready_o),
    .w_valid_i(w_valid_i), .w_last_i(w_last_i), .w_ready_o(w_ready_o),
    .b_valid_o(b_valid_o), .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_ready_i(b_ready_i)
  );

  // Tasks are entered just after a falling edge and leave just after one.
  task automatic test_reset();
    logic [13:0] got, exp;
    rst_i = 1'b1;
    {rd_req_i, r_ready_i, wr_req_i, w_valid_i, w_last_i, b_ready_i} = 6'b0;
    rd_id_i = '0; rd_len_i = '0; wr_id_i = '0; wr_len_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    got = {rd_ready_o, wr_ready_o, r_valid_o, r_last_o, w_ready_o, b_valid_o, r_id_o, b_id_o};
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
    n_total++;
    if (got !== exp) $display("FAIL reset_idle: got %h expected %h", got, exp);
    else n_pass++;
    n_total++;
    if ({r_resp_o, b_resp_o, r_data_o, r_user_o} !== {2'b10, 2'b10, 64'd0, 1'b0})
      $display("FAIL reset_consts: got %h/%h expected 2/2", r_resp_o, b_resp_o);
    else n_pass++;
    rst_i = 1'b0;
  endtask

  // mode 0: r_ready always high, 1: toggles 1/0, 2: random
  task automatic run_read(input logic [IW-1:0] id, input logic [7:0] len, input int mode, input string nm);
    logic [73:0] got, exp;
    int left, guard;
    n_total++;
    if (rd_ready_o !== 1'b1) $display("FAIL %s_ready_before: got %b expected 1", nm, rd_ready_o);
    else n_pass++;
    rd_req_i = 1'b1; rd_id_i = id; rd_len_i = len;
    @(negedge clk_i);
    rd_req_i = 1'b0; rd_id_i = IW'($urandom); rd_len_i = 8'($urandom);
    left = int'(len) + 1;
    guard = 0;
    while (left > 0 && guard < 3000) begin
      exp = {1'b1, (left == 1), id, 64'd0, 2'b10, 1'b0, 1'b0};
      got = {r_valid_o, r_last_o, r_id_o, r_data_o, r_resp_o, r_user_o, rd_ready_o};
      n_total++;
      if (got !== exp) $display("FAIL %s_beat: left=%0d got %h expected %h", nm, left, got, exp);
      else n_pass++;
      case (mode)
        0: r_ready_i = 1'b1;
        1: r_ready_i = guard[0];
        default: r_ready_i = ($urandom_range(99) < 60);
      endcase
      if (r_ready_i) left--;
      @(negedge clk_i);
      guard++;
    end
    r_ready_i = 1'b0;
    n_total++;
    if (left != 0) $display("FAIL %s_timeout: got %0d beats left expected 0", nm, left);
    else n_pass++;
    n_total++;
    if ({r_valid_o, r_last_o, rd_ready_o} !== 3'b001)
      $display("FAIL %s_done: got %b expected 001", nm, {r_valid_o, r_last_o, rd_ready_o});
    else n_pass++;
  endtask

  task automatic run_write(input logic [IW-1:0] id, input logic [7:0] len, input int last_idx,
                           input int bhold, input int wpct, input string nm);
    int term, beat, guard;
    bit done;
    term = CNT_MODE ? int'(len) : last_idx;
    w_valid_i = 1'b1; w_last_i = 1'b0;
    n_total++;
    if ({wr_ready_o, w_ready_o, b_valid_o} !== 3'b100)
      $display("FAIL %s_idle: got %b expected 100", nm, {wr_ready_o, w_ready_o, b_valid_o});
    else n_pass++;
    wr_req_i = 1'b1; wr_id_i = id; wr_len_i = len;
    @(negedge clk_i);
    wr_req_i = 1'b0; wr_id_i = IW'($urandom); wr_len_i = 8'($urandom);
    beat = 0; done = 1'b0; guard = 0;
    while (!done && guard < 3000) begin
      n_total++;
      if ({w_ready_o, b_valid_o, wr_ready_o} !== 3'b100)
        $display("FAIL %s_drain: beat %0d got %b expected 100", nm, beat, {w_ready_o, b_valid_o, wr_ready_o});
      else n_pass++;
      w_valid_i = ($urandom_range(99) < wpct);
      w_last_i = (beat == last_idx);
      if (w_valid_i) begin
        if (beat == term) done = 1'b1;
        beat++;
      end
      @(negedge clk_i);
      guard++;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    n_total++;
    if (!done) $display("FAIL %s_timeout: got %0d beats expected %0d", nm, beat, term + 1);
    else n_pass++;
    for (int i = 0; i <= bhold; i++) begin
      n_total++;
      if ({b_valid_o, b_id_o, b_resp_o, w_ready_o, wr_ready_o} !== {1'b1, id, 2'b10, 1'b0, 1'b0})
        $display("FAIL %s_bresp: cycle %0d got %b/%h expected 1/%h", nm, i, b_valid_o, b_id_o, id);
      else n_pass++;
      b_ready_i = (i == bhold);
      @(negedge clk_i);
    end
    b_ready_i = 1'b0;
    n_total++;
    if ({b_valid_o, wr_ready_o, w_ready_o} !== 3'b010)
      $display("FAIL %s_done: got %b expected 010", nm, {b_valid_o, wr_ready_o, w_ready_o});
    else n_pass++;
  endtask

  task automatic test_read_basic();
    run_read(4'd5, 8'd3, 0, "rd_len3");
    run_read(4'd12, 8'd7, 1, "rd_len7_toggle");
    run_read(4'd0, 8'd0, 0, "rd_len0");
  endtask

  task automatic test_write_basic();
    run_write(4'd9, 8'd1, 1, 3, 100, "wr_len1");
  endtask

  task automatic test_write_term();
    run_write(4'd2, 8'd2, 0, 0, 100, "wr_term");
  endtask

  task automatic test_concurrent_reset();
    int left, rh, wb, wph, nph, guard;
    rd_req_i = 1'b1; rd_id_i = 4'hA; rd_len_i = 8'd15;
    wr_req_i = 1'b1; wr_id_i = 4'h3; wr_len_i = 8'd1;
    @(negedge clk_i);
    rd_req_i = 1'b0; wr_req_i = 1'b0;
    n_total++;
    if ({rd_ready_o, wr_ready_o} !== 2'b00)
      $display("FAIL conc_accept: got %b expected 00", {rd_ready_o, wr_ready_o});
    else n_pass++;
    left = 16; rh = 0; wb = 0; wph = 0; guard = 0;
    while (rh < 5 && guard < 100) begin
      n_total++;
      if ({r_valid_o, r_last_o, r_id_o} !== {1'b1, (left == 1), 4'hA})
        $display("FAIL conc_rbeat: got %b%b/%h expected 1%b/a", r_valid_o, r_last_o, r_id_o, (left == 1));
      else n_pass++;
      n_total++;
      if ({w_ready_o, b_valid_o, wr_ready_o} !== ((wph == 0) ? 3'b100 : (wph == 1) ? 3'b010 : 3'b001))
        $display("FAIL conc_wside: phase %0d got %b", wph, {w_ready_o, b_valid_o, wr_ready_o});
      else n_pass++;
      if (wph == 1) begin
        n_total++;
        if (b_id_o !== 4'h3) $display("FAIL conc_bid: got %h expected 3", b_id_o);
        else n_pass++;
      end
      r_ready_i = 1'b1; left--; rh++;
      w_valid_i = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b0; nph = wph;
      if (wph == 0) begin
        w_valid_i = 1'b1; w_last_i = (wb == 1);
        if (wb == 1) nph = 1;
        wb++;
      end else if (wph == 1) begin
        b_ready_i = 1'b1; nph = 2;
      end
      @(negedge clk_i);
      wph = nph; guard++;
    end
    r_ready_i = 1'b0; w_valid_i = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b0;
    n_total++;
    if ({r_valid_o, r_last_o, wph == 2} !== 3'b101)
      $display("FAIL conc_beat6: got %b%b wph=%0d expected 10 wph=2", r_valid_o, r_last_o, wph);
    else n_pass++;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    n_total++;
    if ({r_valid_o, r_last_o, rd_ready_o, wr_ready_o, w_ready_o, b_valid_o} !== 6'b001100)
      $display("FAIL conc_reset: got %b expected 001100",
               {r_valid_o, r_last_o, rd_ready_o, wr_ready_o, w_ready_o, b_valid_o});
    else n_pass++;
    run_read(4'h6, 8'd0, 0, "rd_after_rst");
  endtask

  task automatic test_random();
    logic [7:0] wl;
    for (int k = 0; k < 6; k++) begin
      run_read(IW'($urandom), 8'($urandom_range(20)), 2, "rd_rand");
      wl = 8'($urandom_range(6));
      run_write(IW'($urandom), wl, int'(wl), $urandom_range(3), 70, "wr_rand");
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_write_term();
    test_concurrent_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
